// File: rtl/wb_arb2_if.sv
// wshb_if: Wishbone B4 classic/registered-feedback bus bundle shared by masters and slaves.
interface wshb_if;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic        we;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        err;
  logic        rty;
  modport master (output adr, dat_ms, we, sel, cti, bte, cyc, stb, input dat_sm, ack, err, rty);
  modport slave  (input adr, dat_ms, we, sel, cti, bte, cyc, stb, output dat_sm, ack, err, rty);
endinterface

// File: rtl/wb_arb2.sv
// wb_arb2: two-master Wishbone arbiter with round-robin ties, cycle lock and strobe timeout abort.
module wb_arb2 #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  wshb_if.slave      wb_m0,
  wshb_if.slave      wb_m1,
  wshb_if.master     wb_s,
  output logic [1:0] grant,
  output logic       timeout_evt
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    grant_q;
  logic          tevt_q;
  logic          req0, req1, own0, own1, own_cyc, own_stb, resp, abort;
  assign req0    = wb_m0.cyc & wb_m0.stb;
  assign req1    = wb_m1.cyc & wb_m1.stb;
  assign own0    = state_q == OWN0;
  assign own1    = state_q == OWN1;
  assign own_cyc = own0 ? wb_m0.cyc : own1 & wb_m1.cyc;
  assign own_stb = own0 ? wb_m0.stb : own1 & wb_m1.stb;
  assign resp    = wb_s.ack | wb_s.err | wb_s.rty;
  // tevt_q is set exactly when the counter lands on TIMEOUT, so it marks the abort cycle itself
  assign abort   = tevt_q;
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = (req0 & (~req1 | last_q)) ? OWN0 : req1 ? OWN1 : IDLE;
      OWN0:    state_d = abort ? IDLE : wb_m0.cyc ? OWN0 : req1 ? OWN1 : IDLE;
      OWN1:    state_d = abort ? IDLE : wb_m1.cyc ? OWN1 : req0 ? OWN0 : IDLE;
      default: state_d = IDLE;
    endcase
    last_d = state_d == OWN0 ? 1'b0 : state_d == OWN1 ? 1'b1 : last_q;
    cnt_d  = (state_d != state_q || !own_stb || resp) ? '0
           : cnt_q + CW'(cnt_q != CW'(TIMEOUT));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      grant_q <= 2'b00;
      tevt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      grant_q <= {state_d == OWN1, state_d == OWN0};
      tevt_q  <= cnt_d == CW'(TIMEOUT);
    end
  end
  assign wb_s.adr    = own0 ? wb_m0.adr    : own1 ? wb_m1.adr    : '0;
  assign wb_s.dat_ms = own0 ? wb_m0.dat_ms : own1 ? wb_m1.dat_ms : '0;
  assign wb_s.we     = own0 ? wb_m0.we     : own1 & wb_m1.we;
  assign wb_s.sel    = own0 ? wb_m0.sel    : own1 ? wb_m1.sel    : '0;
  assign wb_s.cti    = own0 ? wb_m0.cti    : own1 ? wb_m1.cti    : '0;
  assign wb_s.bte    = own0 ? wb_m0.bte    : own1 ? wb_m1.bte    : '0;
  assign wb_s.cyc    = own_cyc & ~abort;
  assign wb_s.stb    = own_stb & ~abort;
  assign wb_m0.ack    = own0 & ~abort & wb_s.ack;
  assign wb_m0.err    = own0 & (abort | wb_s.err);
  assign wb_m0.rty    = own0 & ~abort & wb_s.rty;
  assign wb_m1.ack    = own1 & ~abort & wb_s.ack;
  assign wb_m1.err    = own1 & (abort | wb_s.err);
  assign wb_m1.rty    = own1 & ~abort & wb_s.rty;
  assign wb_m0.dat_sm = wb_s.dat_sm;
  assign wb_m1.dat_sm = wb_s.dat_sm;
  assign grant       = grant_q;
  assign timeout_evt = tevt_q;
endmodule

// File: tb/tb_wb_arb2.sv
// tb_wb_arb2: table vectors, directed corner sequences and randomized traffic against an ownership/memory model.
module tb_wb_arb2;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] grant;
  logic       timeout_evt;
  wshb_if m0_if ();
  wshb_if m1_if ();
  wshb_if s_if ();
  wb_arb2 #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .wb_m0(m0_if), .wb_m1(m1_if), .wb_s(s_if),
    .grant(grant), .timeout_evt(timeout_evt)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  int smode = 0;
  logic ack_en = 1'b1;
  logic [31:0] mem [16] = '{default: '0};
  logic [31:0] ref_mem [16] = '{default: '0};
  assign s_if.ack = (smode == 3) || (s_if.cyc && s_if.stb && (smode == 0 || (smode == 1 && ack_en)));
  assign s_if.err = 1'b0;
  assign s_if.rty = 1'b0;
  assign s_if.dat_sm = mem[s_if.adr[3:0]];
  always @(posedge clk) begin
    ack_en <= $urandom_range(0, 3) != 0;
    if (s_if.cyc && s_if.stb && s_if.ack && s_if.we) mem[s_if.adr[3:0]] <= s_if.dat_ms;
  end
  wire r0 = m0_if.cyc & m0_if.stb;
  wire r1 = m1_if.cyc & m1_if.stb;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic drive(input int m, input logic c, input logic s, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    if (m == 0) begin
      m0_if.cyc = c; m0_if.stb = s; m0_if.we = w; m0_if.adr = a; m0_if.dat_ms = d; m0_if.cti = t;
    end else begin
      m1_if.cyc = c; m1_if.stb = s; m1_if.we = w; m1_if.adr = a; m1_if.dat_ms = d; m1_if.cti = t;
    end
  endtask
  function automatic logic ack_of(input int m);
    return m == 0 ? m0_if.ack : m1_if.ack;
  endfunction
  function automatic logic [31:0] dat_of(input int m);
    return m == 0 ? m0_if.dat_sm : m1_if.dat_sm;
  endfunction
  task automatic txn(input int m, input logic w, input logic [3:0] a, input logic [31:0] d,
                     output logic [31:0] rd);
    bit ok = 0;
    rd = '0;
    drive(m, 1'b1, 1'b1, w, {28'b0, a}, d, 3'b000);
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (ack_of(m)) begin
        ok = 1;
        rd = dat_of(m);
        if (w) ref_mem[a] = d;
        else chk($sformatf("read_m%0d_adr%0d", m, a), rd, ref_mem[a]);
      end
      @(posedge clk); #1;
    end
    drive(m, 1'b0, 1'b0, 1'b0, '0, '0, 3'b000);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL ack_wait_m%0d: no ack within 200 cycles, ack required", m);
    end
  endtask
  task automatic rst_pulse();
    @(posedge clk); #3 rst = 1'b0;
    #4 rst = 1'b1;
    @(posedge clk); #1;
  endtask
  int   exp_own = 0;
  logic exp_last = 1'b1;
  bit   mon_on = 0;
  int   ack_q[$];
  always @(negedge clk) if (mon_on) begin
    chk("grant", {30'b0, grant}, exp_own == 1 ? 32'd1 : exp_own == 2 ? 32'd2 : 32'd0);
    chk("bcast_dat", m0_if.dat_sm ^ m1_if.dat_sm ^ s_if.dat_sm, s_if.dat_sm);
    if (exp_own != 1) chk("iso_m0", {m0_if.ack, m0_if.err, m0_if.rty}, 0);
    if (exp_own != 2) chk("iso_m1", {m1_if.ack, m1_if.err, m1_if.rty}, 0);
    if (exp_own == 0) chk("idle_bus", {s_if.cyc, s_if.stb, s_if.we, s_if.sel}, 0);
    if (exp_own == 1) begin
      chk("route_m0", {s_if.cyc, s_if.stb, s_if.we, s_if.adr[27:0]}, {m0_if.cyc, m0_if.stb, m0_if.we, m0_if.adr[27:0]});
      chk("fwd_ack_m0", m0_if.ack, s_if.ack);
    end
    if (exp_own == 2) begin
      chk("route_m1", {s_if.cyc, s_if.stb, s_if.we, s_if.adr[27:0]}, {m1_if.cyc, m1_if.stb, m1_if.we, m1_if.adr[27:0]});
      chk("fwd_ack_m1", m1_if.ack, s_if.ack);
    end
    if (m0_if.ack) ack_q.push_back(1);
    if (m1_if.ack) ack_q.push_back(2);
    if (exp_own == 0) exp_own = (r0 && (!r1 || exp_last)) ? 1 : r1 ? 2 : 0;
    else if (exp_own == 1 && !m0_if.cyc) exp_own = r1 ? 2 : 0;
    else if (exp_own == 2 && !m1_if.cyc) exp_own = r0 ? 1 : 0;
    if (exp_own != 0) exp_last = exp_own == 2;
  end
  typedef struct {
    logic [3:0] req;
    logic [1:0] exp_grant;
  } vec_t;
  vec_t tbl[12];
  logic [31:0] rd0, rd1, rr0, rr1;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    // req = {cyc0, stb0, cyc1, stb1}; ties alternate starting with m0
    tbl = '{'{4'b0000, 2'b00}, '{4'b1100, 2'b01}, '{4'b0011, 2'b10}, '{4'b1111, 2'b01},
            '{4'b1111, 2'b10}, '{4'b1000, 2'b00}, '{4'b0100, 2'b00}, '{4'b1011, 2'b10},
            '{4'b1111, 2'b01}, '{4'b0010, 2'b00}, '{4'b1111, 2'b10}, '{4'b1110, 2'b01}};
    m0_if.sel = 4'hF; m0_if.bte = 2'b00;
    m1_if.sel = 4'hF; m1_if.bte = 2'b00;
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0, 3'b000);
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0, 3'b000);
    @(negedge clk);
    chk("rst_grant", {30'b0, grant}, 0);
    chk("rst_tevt", timeout_evt, 0);
    drive(0, 1'b1, 1'b1, 1'b1, 32'h3, 32'h77, 3'b000);
    #1 chk("rst_bus", {s_if.cyc, s_if.stb, s_if.we, s_if.sel, m0_if.ack, m0_if.err, m0_if.rty}, 0);
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0, 3'b000);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 12; k++) begin
      drive(0, tbl[k].req[3], tbl[k].req[2], 1'b0, '0, '0, 3'b000);
      drive(1, tbl[k].req[1], tbl[k].req[0], 1'b0, '0, '0, 3'b000);
      @(negedge clk);
      chk($sformatf("tbl%0d_idle_cyc", k), {s_if.cyc, s_if.stb}, 0);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 1'b0, '0, '0, 3'b000);
      drive(1, 1'b0, 1'b0, 1'b0, '0, '0, 3'b000);
      @(negedge clk);
      chk($sformatf("tbl%0d_grant", k), {30'b0, grant}, {30'b0, tbl[k].exp_grant});
      repeat (2) @(posedge clk);
      #1;
    end
    rst_pulse();
    exp_own = 0; exp_last = 1'b1; ack_q.delete(); mon_on = 1;
    fork
      for (int i = 0; i < 4; i++) begin
        txn(0, 1'b1, 4'(i), 32'hC0DE_0000 + i, rd0);
        @(posedge clk); #1;
      end
      for (int i = 0; i < 4; i++) begin
        txn(1, 1'b0, 4'(i), 32'h0, rd1);
        @(posedge clk); #1;
      end
    join
    chk("rr_ack_count", ack_q.size(), 8);
    for (int k = 0; k < ack_q.size() && k < 8; k++) chk($sformatf("rr_ack_order%0d", k), ack_q[k], (k % 2) ? 2 : 1);
    repeat (3) @(posedge clk);
    #1;
    drive(1, 1'b1, 1'b1, 1'b0, 32'd8, '0, 3'b010);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 1'b0, 32'd0, '0, 3'b000);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("burst_grant%0d", k), {30'b0, grant}, 2);
      chk($sformatf("burst_ack%0d", k), {m1_if.ack, m0_if.ack}, 2'b10);
      @(posedge clk); #1;
      if (k < 7) drive(1, 1'b1, 1'b1, 1'b0, 32'(9 + k), '0, 3'b010);
      else drive(1, 1'b0, 1'b0, 1'b0, '0, '0, 3'b000);
    end
    @(negedge clk);
    chk("burst_tail_grant", {30'b0, grant}, 2);
    @(negedge clk);
    chk("burst_handoff_grant", {30'b0, grant}, 1);
    chk("burst_handoff_ack", m0_if.ack, 1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0, 3'b000);
    repeat (3) @(posedge clk);
    #1;
    fork
      txn(0, 1'b1, 4'd5, 32'hA5A5_0001, rd0);
      begin
        @(posedge clk); #1;
        txn(1, 1'b0, 4'd5, 32'h0, rd1);
      end
    join
    chk("iso_readback", rd1, 32'hA5A5_0001);
    smode = 1;
    fork
      for (int i = 0; i < 25; i++) begin
        txn(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, rr0);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      for (int i = 0; i < 25; i++) begin
        txn(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, rr1);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    mon_on = 0;
    smode = 2;
    drive(0, 1'b1, 1'b1, 1'b1, 32'd3, 32'h1234, 3'b000);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("to_wait%0d", i), {grant, m0_if.err, timeout_evt}, 4'b0100);
      @(posedge clk); #1;
    end
    smode = 3;
    @(negedge clk);
    chk("to_abort", {m0_if.err, m0_if.ack, timeout_evt, s_if.cyc, s_if.stb}, 5'b10100);
    @(posedge clk); #1;
    smode = 0;
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0, 3'b000);
    @(negedge clk);
    chk("to_after", {grant, m0_if.err, timeout_evt}, 4'b0000);
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b1, 1'b0, 32'd9, '0, 3'b010);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("arst_now", {grant, s_if.cyc, s_if.stb, m1_if.ack}, 0);
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0, 3'b000);
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b1, 1'b0, 32'd2, '0, 3'b000);
    @(negedge clk);
    chk("arst_idle", {30'b0, grant}, 0);
    @(negedge clk);
    chk("arst_regrant", {30'b0, grant}, 2);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0, 3'b000);
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
